// File: rtl/prince_sbox_layer_sched.sv
// Sequencer for a nibble-serial 4-share TI PRINCE S-box layer: read issue, valid-gated stage enables, write-back.
// Optional stall input under macro SBOX_SCHED_STALL_EN.
module prince_sbox_layer_sched #(
    parameter int unsigned  NIBBLES     = 16,
    parameter int unsigned  PIPE_STAGES = 3,
    localparam int unsigned IDXW        = $clog2(NIBBLES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   inv_i,
`ifdef SBOX_SCHED_STALL_EN
    input  logic                   stall_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sel_inv_o,
    output logic                   rd_en_o,
    output logic [IDXW-1:0]        rd_idx_o,
    output logic [PIPE_STAGES-1:0] stage_en_o,
    output logic                   wr_en_o,
    output logic [IDXW-1:0]        wr_idx_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         issue_q, issue_d;
    logic [IDXW-1:0]         wr_q, wr_d;
    logic [PIPE_STAGES-1:0]  v_q, v_d;
    logic                    sel_inv_q, sel_inv_d;
    logic                    stall;

    // Stall only freezes an active layer; IDLE and the DONE pulse are unaffected.
`ifdef SBOX_SCHED_STALL_EN
    assign stall = stall_i && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
`else
    assign stall = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_ISSUE;
            S_ISSUE: if (!stall && (issue_q == LAST_IDX)) state_d = S_DRAIN;
            S_DRAIN: if (wr_en_o && (wr_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; stage k is enabled only when stage k-1 holds a valid nibble
    always_comb begin
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        rd_en_o    = (state_q == S_ISSUE) && !stall;
        wr_en_o    = v_q[PIPE_STAGES-1] && !stall;
        rd_idx_o   = issue_q;
        wr_idx_o   = wr_q;
        sel_inv_o  = sel_inv_q;
        stage_en_o = '0;
        if (!stall) begin
            stage_en_o    = v_q << 1;
            stage_en_o[0] = rd_en_o;
        end
    end

    // Counters, valid shift register and inverse select
    always_comb begin
        issue_d   = issue_q;
        wr_d      = wr_q;
        v_d       = v_q;
        sel_inv_d = sel_inv_q;
        if ((state_q == S_IDLE) && start_i) begin
            sel_inv_d = inv_i;
        end
        if (rd_en_o) begin
            issue_d = (issue_q == LAST_IDX) ? '0 : issue_q + IDXW'(1);
        end
        if (wr_en_o) begin
            wr_d = (wr_q == LAST_IDX) ? '0 : wr_q + IDXW'(1);
        end
        if (!stall) begin
            v_d    = v_q << 1;
            v_d[0] = rd_en_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q   <= '0;
            wr_q      <= '0;
            v_q       <= '0;
            sel_inv_q <= 1'b0;
        end else begin
            issue_q   <= issue_d;
            wr_q      <= wr_d;
            v_q       <= v_d;
            sel_inv_q <= sel_inv_d;
        end
    end

endmodule

// File: doc/prince_sbox_layer_sched.md
Name: prince_sbox_layer_sched

Overview:
- Sequencer for a nibble-serial, 4-share threshold-implementation PRINCE S-box layer.
- A single shared TI S-box datapath (affine A-boxes around pipelined quadratic stages) processes all 16 nibbles of the masked state.
- Issues nibble read indices, clocks each register stage only when it holds valid data (glitch/leak hygiene), generates write-back indices, and selects forward or inverse affine set.
- Sits between the round FSM and the share-state register file.

Parameters:
- NIBBLES, 16, nibbles per layer; width of index = clog2(NIBBLES).
- PIPE_STAGES, 3, register stages in the shared TI S-box datapath (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request one full S-box layer; sampled only in IDLE.
- inv_i  in  1  0 = forward S-box, 1 = inverse; latched when start accepted.
- busy_o  out  1  layer in progress.
- done_o  out  1  one-cycle pulse: last nibble written back.
- sel_inv_o  out  1  latched inv_i, drives affine/negation select of the datapath.
- rd_en_o  out  1  read nibble rd_idx_o from all 4 share registers into the datapath.
- rd_idx_o  out  IDXW  nibble index being issued.
- stage_en_o  out  PIPE_STAGES  per-stage register enable of the datapath.
- wr_en_o  out  1  write datapath output into all 4 shares at wr_idx_o.
- wr_idx_o  out  IDXW  nibble index being written back.

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0; FSM state IDLE; counters 0; valid shift register 0; sel_inv_o 0. Reset mid-layer aborts immediately, with no partial done.
- FSM states:
  - IDLE: start_i=1 in cycle t → latch inv_i into sel_inv_o; go to ISSUE at t+1.
  - ISSUE: rd_en_o=1 and rd_idx_o=issue counter (0..NIBBLES-1, +1 per cycle). After index NIBBLES-1 is issued → DRAIN.
  - DRAIN: rd_en_o=0; wait until the valid shift register is empty and the last write has happened → DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- busy_o=1 in ISSUE, DRAIN and DONE; 0 in IDLE.
- Valid pipeline v[0..P-1], with P=PIPE_STAGES:
  - v[0]<=rd_en_o; v[k]<=v[k-1].
  - stage_en_o[0]=rd_en_o; stage_en_o[k]=v[k-1] for k>=1.
  - wr_en_o=v[P-1], combinational from registers.
- wr_idx_o comes from its own counter, incremented on each wr_en_o. Write order equals issue order (0..NIBBLES-1).
- Timing with start in cycle 0:
  - reads in cycles 1..NIBBLES;
  - writes in cycles 1+P..NIBBLES+P;
  - done_o in cycle NIBBLES+P+1.
  - Defaults: reads 1..16, writes 4..19, done 20; total 21 cycles including the start cycle.
- start_i while busy_o=1 is ignored, with no queueing. start_i in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.
- sel_inv_o holds constant for the whole layer; an inv_i change while busy has no effect. sel_inv_o retains its value in IDLE until the next start.
- Counters wrap to 0 after NIBBLES-1. Both counters are 0 whenever the FSM is in IDLE.
- Stage enables are never asserted for an empty stage: no stage_en_o bit is 1 in IDLE or DONE.

Optional Feature:
- Macro SBOX_SCHED_STALL_EN.
- Defined:
  - Adds input stall_i (1 bit).
  - While stall_i=1: rd_en_o, stage_en_o, wr_en_o forced 0; counters, v[] and FSM frozen; busy_o stays 1.
  - Each stall cycle extends completion by one cycle.
  - stall_i in IDLE has no effect; start is still accepted.
- Undefined: no stall_i port; the timing above is exact.

Test Plan:
- Reset/idle: rst_n=0 then release, no start → all outputs 0 for 50 cycles; stage_en_o=0.
- Forward layer: start_i=1, inv_i=0 at cycle 0 → rd_idx_o 0..15 in cycles 1..16; wr_idx_o 0..15 with wr_en_o in cycles 4..19; done_o only in cycle 20; sel_inv_o=0.
- Inverse + ignored start: start with inv_i=1; toggle inv_i and pulse start_i at cycle 8 → sel_inv_o=1 throughout; exactly one done at cycle 20; no second layer.
- Back-to-back: start held high continuously → layers begin at cycles 0 and 21 (one IDLE cycle between); done at 20 and 41.
- Async reset mid-layer: rst_n low at cycle 10 (asynchronous, between edges) → outputs 0 immediately; no done; a new start after release gives the full 0..15 sequence.
- Stall (SBOX_SCHED_STALL_EN): stall_i=1 for cycles 5..7 → no enables in those cycles; indices resume unchanged; done at cycle 23.
